serial_rx_frame: RTL and testbench
==================================

// Module: serial_rx_frame
// PURPOSE
//  Parametrised serial frame receiver for the on-chip serial link. Detects a start bit, samples DATA_W
//  data bits LSB-first, plus an optional parity bit and an optional stop bit, at CLKS_PER_BIT clocks/bit.
//  Delivers each frame through a valid/ready output register, with parity, framing and overrun status.
//  Sits between the link pin (same clk domain as the transmitter) and the consumer logic.
// PARAMETERS
//  DATA_W        7  data bits per frame (1..16)
//  CLKS_PER_BIT  1  clk cycles per serial bit (>=1); sampling point is mid-bit
//  PARITY_EN     1  1: parity bit follows data; 0: no parity bit
//  PARITY_ODD    1  1: odd parity (XOR of data+parity must be 1); 0: even (XOR must be 0)
//  STOP_EN       1  1: one stop bit (must be 1) ends the frame; 0: no stop bit
// PORTS
//  clk           in   1       clock
//  rstn          in   1       asynchronous reset, active low
//  serial_in     in   1       serial line, idle high, synchronous to clk
//  m_valid       out  1       frame available in output register
//  m_ready       in   1       consumer accepts frame when m_valid && m_ready
//  m_data        out  DATA_W  received data, bit 0 = first bit on the line
//  m_parity_err  out  1       parity check failed (always 0 when PARITY_EN=0)
//  m_frame_err   out  1       stop bit sampled 0 (always 0 when STOP_EN=0)
//  overrun       out  1       one-cycle pulse: completed frame dropped because output register was full
//  busy          out  1       1 in any state other than IDLE
// BEHAVIOUR
//  - Reset: m_valid=0, m_data=0, m_parity_err=0, m_frame_err=0, overrun=0, busy=0, state=IDLE,
//    line history reg=1. Reset mid-frame abandons the frame; no partial output is ever delivered.
//  - Let H=(CLKS_PER_BIT-1)/2 (integer). Start edge: in IDLE, history=1 and serial_in=0 at cycle t0.
//  - FSM: IDLE -> START -> DATA -> [PARITY] -> [STOP] -> IDLE.
//    START: serial_in sampled at t0+H; if 1, this is a glitch -> IDLE with no output; else -> DATA.
//    Then each further bit is sampled every CLKS_PER_BIT cycles: data bit k at t0+(k+1)*CLKS_PER_BIT+H.
//    For CLKS_PER_BIT=1 the START check occurs at t0 itself and data bit 0 is sampled at t0+1.
//  - Bit timer: counts 0..CLKS_PER_BIT-1, emits a sample tick; width $clog2(CLKS_PER_BIT+1).
//  - Bit counter counts data bits 0..DATA_W-1, width $clog2(DATA_W+1); data shift register is LSB-first.
//  - Parity error = (^{data,parity_bit}) != PARITY_ODD.
//  - Completion: the cycle after the final sample (stop, else parity, else last data bit), the frame
//    loads into the output register and m_valid rises. With defaults, m_valid rises at t0+10.
//  - Output register holds its contents and m_valid until a handshake (m_valid && m_ready).
//  - Completion while m_valid=1 and m_ready=0: new frame dropped, output register unchanged, overrun=1
//    for one cycle. Completion with m_valid=1 and m_ready=1 in the same cycle: old frame consumed, new
//    frame loaded, m_valid stays 1, no overrun.
//  - After STOP (or last field), returns to IDLE; a line still low (break or framing error) does not
//    start a new frame until it returns high and falls again (edge detection via the history reg).
//  - serial_in edges during DATA, PARITY or STOP are ignored; only the sample ticks matter.
// STRUCTURE
//  - serial_pkg: FSM state enum (IDLE, START, DATA, PARITY, STOP), parity-mode localparams,
//    frame-length function F = 1+DATA_W+PARITY_EN+STOP_EN, shared with the transmitter.
//  - One sub-module: serial_bit_timer (CLKS_PER_BIT counter, restart on start edge, tick output).
// TESTING
//  1. Defaults, frame 0,1,0,1,0,1,0,1,1,1 (start, 7'h55 LSB-first, parity 1, stop) with m_ready=1
//     -> m_valid pulses at t0+10, m_data=7'h55, m_parity_err=0, m_frame_err=0.
//  2. Defaults, 7'h55 sent with parity bit 0 -> m_data=7'h55, m_parity_err=1; stop bit 0 -> m_frame_err=1.
//  3. m_ready=0, two back-to-back 7'h12 then 7'h34 -> first frame held; overrun pulses 1 cycle at the
//     second completion; m_data stays 7'h12; the handshake then clears m_valid.
//  4. CLKS_PER_BIT=16, DATA_W=8, PARITY_EN=0: 8'hA5 -> sampling at t0+16k+23; m_data=8'hA5;
//     a 3-cycle low glitch on the idle line -> no m_valid, busy drops by t0+8.
//  5. Deassert rstn during data bit 3 -> all outputs 0 immediately; the next clean frame 7'h3C is
//     received correctly.
//  6. Line held low for 30 cycles after a frame -> exactly one m_valid with m_frame_err=1, no spurious
//     second frame.

Source files
------------

// File: rtl/serial_pkg.sv
// Types and constants shared by the serial link receiver and transmitter.
package serial_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } rx_state_e;

  localparam int PARITY_MODE_EVEN = 0;
  localparam int PARITY_MODE_ODD  = 1;

  // Total bit periods on the line for one frame, start bit included.
  function automatic int frame_len(input int data_w, input int parity_en, input int stop_en);
    return 1 + data_w + parity_en + stop_en;
  endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// Bit-period timer: emits a tick at mid-bit, realigned to the start edge by restart_i.
module serial_bit_timer #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rstn,
  input  logic restart_i,
  output logic tick_o
);

  localparam int CNT_W       = $clog2(CLKS_PER_BIT + 1);
  localparam int HALF        = (CLKS_PER_BIT - 1) / 2;
  // Preload so the first tick lands HALF cycles after the start edge; HALF=0 ticks on the edge itself.
  localparam int RESTART_VAL = (CLKS_PER_BIT - HALF) % CLKS_PER_BIT;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wrap;

  assign wrap   = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
  assign tick_o = restart_i ? (HALF == 0) : wrap;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    cnt_d = wrap ? '0 : cnt_q + 1'b1;
    if (restart_i) cnt_d = CNT_W'(RESTART_VAL);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/serial_rx_frame.sv
// Serial frame receiver: start/data/parity/stop sampling FSM feeding a valid/ready output register.
module serial_rx_frame
  import serial_pkg::*;
#(
  parameter int DATA_W       = 7,
  parameter int CLKS_PER_BIT = 1,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = PARITY_MODE_ODD,
  parameter int STOP_EN      = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              serial_in,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_parity_err,
  output logic              m_frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  rx_state_e         state_q, state_d;
  logic              hist_q;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] data_q, data_d, shift_data, fin_data;
  logic              par_q, par_d, fin_par;
  logic              tick, start_edge, last_bit, done, par_err, frame_err;

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              perr_q, perr_d, ferr_q, ferr_d, ovr_q, ovr_d;

  assign start_edge = (state_q == S_IDLE) && hist_q && !serial_in;
  assign last_bit   = (bit_cnt_q == CNT_W'(DATA_W - 1));

  serial_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk       (clk),
    .rstn      (rstn),
    .restart_i (start_edge),
    .tick_o    (tick)
  );

  always_comb begin
    shift_data           = data_q >> 1;
    shift_data[DATA_W-1] = serial_in;
  end

  // The final field is folded in combinationally so the frame loads on the edge of its last sample.
  assign fin_data  = (state_q == S_DATA) ? shift_data : data_q;
  assign fin_par   = (state_q == S_PARITY) ? serial_in : par_q;
  assign par_err   = (PARITY_EN != 0) && ((^{fin_data, fin_par}) != 1'(PARITY_ODD));
  assign frame_err = (STOP_EN != 0) && (state_q == S_STOP) && !serial_in;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    data_d    = data_q;
    par_d     = par_q;
    done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        bit_cnt_d = '0;
        if (start_edge) state_d = tick ? S_DATA : S_START;
      end
      S_START: begin
        if (tick) state_d = serial_in ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (tick) begin
          data_d    = shift_data;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (last_bit) begin
            if (PARITY_EN != 0)    state_d = S_PARITY;
            else if (STOP_EN != 0) state_d = S_STOP;
            else begin
              state_d = S_IDLE;
              done    = 1'b1;
            end
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          par_d = serial_in;
          if (STOP_EN != 0) state_d = S_STOP;
          else begin
            state_d = S_IDLE;
            done    = 1'b1;
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          state_d = S_IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    valid_d    = valid_q;
    out_data_d = out_data_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    ovr_d      = 1'b0;
    if (done) begin
      if (!valid_q || m_ready) begin
        valid_d    = 1'b1;
        out_data_d = fin_data;
        perr_d     = par_err;
        ferr_d     = frame_err;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && m_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      hist_q     <= 1'b1;
      bit_cnt_q  <= '0;
      data_q     <= '0;
      par_q      <= 1'b0;
      valid_q    <= 1'b0;
      out_data_q <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      state_q    <= state_d;
      hist_q     <= serial_in;
      bit_cnt_q  <= bit_cnt_d;
      data_q     <= data_d;
      par_q      <= par_d;
      valid_q    <= valid_d;
      out_data_q <= out_data_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
    end
  end

  assign m_valid      = valid_q;
  assign m_data       = out_data_q;
  assign m_parity_err = perr_q;
  assign m_frame_err  = ferr_q;
  assign overrun      = ovr_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_serial_rx_frame.sv
// Directed bench: default receiver plus a 16x-oversampled 8-bit, no-parity instance.
module tb_serial_rx_frame;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic       si = 1'b1, rdy = 1'b1;
  logic       vld, perr, ferr, ovr, bsy;
  logic [6:0] dat;

  logic       si16 = 1'b1, rdy16 = 1'b1;
  logic       vld16, perr16, ferr16, ovr16, bsy16;
  logic [7:0] dat16;

  int checks = 0;
  int errors = 0;

  serial_rx_frame dut (
    .clk(clk), .rstn(rstn), .serial_in(si), .m_valid(vld), .m_ready(rdy), .m_data(dat),
    .m_parity_err(perr), .m_frame_err(ferr), .overrun(ovr), .busy(bsy)
  );

  serial_rx_frame #(.DATA_W(8), .CLKS_PER_BIT(16), .PARITY_EN(0)) dut16 (
    .clk(clk), .rstn(rstn), .serial_in(si16), .m_valid(vld16), .m_ready(rdy16), .m_data(dat16),
    .m_parity_err(perr16), .m_frame_err(ferr16), .overrun(ovr16), .busy(bsy16)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one default-format frame, one bit per cycle starting at t0; returns in cycle t0+10.
  task automatic send_frame(input logic [6:0] d, input logic par, input logic stp,
                            output logic pre_valid, output logic pre_ovr);
    logic [9:0] bits;
    bits = {stp, par, d, 1'b0};
    pre_valid = 1'b0;
    pre_ovr   = 1'b0;
    for (int i = 0; i < 10; i++) begin
      si = bits[i];
      if (i == 9) begin
        pre_valid = vld;
        pre_ovr   = ovr;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) step();
    checks++; if (vld !== 1'b0)  begin errors++; $display("FAIL reset_valid: got %b expected 0", vld); end
    checks++; if (dat !== 7'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", dat); end
    checks++; if ({perr, ferr, ovr, bsy} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {perr, ferr, ovr, bsy}); end
    checks++; if ({vld16, bsy16, dat16} !== 10'b0) begin errors++; $display("FAIL reset_16x: got %h expected 000", {vld16, bsy16, dat16}); end
    rstn = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_basic();
    logic pv, po;
    rdy = 1'b1;
    send_frame(7'h55, 1'b1, 1'b1, pv, po);
    si = 1'b1;
    checks++; if (pv !== 1'b0)   begin errors++; $display("FAIL basic_early_valid: got %b expected 0 at t0+9", pv); end
    checks++; if (vld !== 1'b1)  begin errors++; $display("FAIL basic_valid: got %b expected 1 at t0+10", vld); end
    checks++; if (dat !== 7'h55) begin errors++; $display("FAIL basic_data: got %h expected 55", dat); end
    checks++; if ({perr, ferr} !== 2'b00) begin errors++; $display("FAIL basic_errs: got %b expected 00", {perr, ferr}); end
    checks++; if (bsy !== 1'b0)  begin errors++; $display("FAIL basic_busy: got %b expected 0", bsy); end
    step();
    checks++; if (vld !== 1'b0)  begin errors++; $display("FAIL basic_handshake: got %b expected 0", vld); end
  endtask

  task automatic test_errors();
    logic pv, po;
    send_frame(7'h55, 1'b0, 1'b1, pv, po);
    si = 1'b1;
    checks++; if ({vld, dat} !== {1'b1, 7'h55}) begin errors++; $display("FAIL perr_frame: got %h expected d5", {vld, dat}); end
    checks++; if ({perr, ferr} !== 2'b10) begin errors++; $display("FAIL perr_flags: got %b expected 10", {perr, ferr}); end
    step();
    send_frame(7'h55, 1'b1, 1'b0, pv, po);
    si = 1'b1;
    checks++; if (vld !== 1'b1) begin errors++; $display("FAIL ferr_valid: got %b expected 1", vld); end
    checks++; if ({perr, ferr} !== 2'b01) begin errors++; $display("FAIL ferr_flags: got %b expected 01", {perr, ferr}); end
    repeat (3) step();
  endtask

  task automatic test_overrun();
    logic pv, po;
    rdy = 1'b0;
    send_frame(7'h12, 1'b1, 1'b1, pv, po);
    checks++; if ({vld, dat} !== {1'b1, 7'h12}) begin errors++; $display("FAIL ovr_first: got %h expected 92", {vld, dat}); end
    send_frame(7'h34, 1'b0, 1'b1, pv, po);
    si = 1'b1;
    checks++; if (po !== 1'b0)  begin errors++; $display("FAIL ovr_early: got %b expected 0 at t0+19", po); end
    checks++; if (ovr !== 1'b1) begin errors++; $display("FAIL ovr_pulse: got %b expected 1 at t0+20", ovr); end
    checks++; if ({vld, dat, perr} !== {1'b1, 7'h12, 1'b0}) begin errors++; $display("FAIL ovr_held: got %h expected 124", {vld, dat, perr}); end
    step();
    checks++; if ({ovr, vld} !== 2'b01) begin errors++; $display("FAIL ovr_one_cycle: got %b expected 01", {ovr, vld}); end
    rdy = 1'b1;
    step();
    checks++; if (vld !== 1'b0) begin errors++; $display("FAIL ovr_drain: got %b expected 0", vld); end
  endtask

  task automatic test_reset_mid();
    logic pv, po;
    logic [9:0] bits;
    rdy = 1'b0;
    send_frame(7'h55, 1'b1, 1'b1, pv, po);
    si = 1'b1;
    step();
    bits = {1'b1, 1'b1, 7'h3C, 1'b0};
    for (int i = 0; i < 4; i++) begin
      si = bits[i];
      step();
    end
    si = bits[4];
    checks++; if ({vld, bsy} !== 2'b11) begin errors++; $display("FAIL rst_mid_before: got %b expected 11", {vld, bsy}); end
    rstn = 1'b0;
    #1;
    checks++; if ({vld, bsy, ovr, perr, ferr} !== 5'b0) begin errors++; $display("FAIL rst_mid_flags: got %b expected 00000", {vld, bsy, ovr, perr, ferr}); end
    checks++; if (dat !== 7'h00) begin errors++; $display("FAIL rst_mid_data: got %h expected 00", dat); end
    step();
    si = 1'b1;
    rdy = 1'b1;
    rstn = 1'b1;
    repeat (2) step();
    send_frame(7'h3C, 1'b1, 1'b1, pv, po);
    si = 1'b1;
    checks++; if ({vld, dat} !== {1'b1, 7'h3C}) begin errors++; $display("FAIL rst_mid_next: got %h expected bc", {vld, dat}); end
    checks++; if ({perr, ferr} !== 2'b00) begin errors++; $display("FAIL rst_mid_next_errs: got %b expected 00", {perr, ferr}); end
    repeat (2) step();
  endtask

  task automatic test_break();
    logic pv, po;
    int extra;
    rdy = 1'b1;
    send_frame(7'h55, 1'b1, 1'b0, pv, po);
    checks++; if ({vld, ferr} !== 2'b11) begin errors++; $display("FAIL break_frame: got %b expected 11", {vld, ferr}); end
    extra = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (vld || bsy) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL break_spurious: got %0d expected 0", extra); end
    si = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_oversample();
    logic [9:0] bits;
    int glitch_valid;
    bits = {1'b1, 8'hA5, 1'b0};
    // Each data/stop bit is correct only at its mid-bit sample cycle, inverted elsewhere.
    for (int cyc = 0; cyc < 160; cyc++) begin
      if (cyc > 151)             si16 = 1'b1;
      else if (cyc < 16)         si16 = 1'b0;
      else if ((cyc % 16) == 7)  si16 = bits[cyc / 16];
      else                       si16 = ~bits[cyc / 16];
      step();
      if (cyc + 1 == 151) begin
        checks++; if (vld16 !== 1'b0) begin errors++; $display("FAIL os_early_valid: got %b expected 0 at t0+151", vld16); end
      end
      if (cyc + 1 == 152) begin
        checks++; if (vld16 !== 1'b1)  begin errors++; $display("FAIL os_valid: got %b expected 1 at t0+152", vld16); end
        checks++; if (dat16 !== 8'hA5) begin errors++; $display("FAIL os_data: got %h expected a5", dat16); end
        checks++; if ({perr16, ferr16} !== 2'b00) begin errors++; $display("FAIL os_errs: got %b expected 00", {perr16, ferr16}); end
      end
    end
    si16 = 1'b1;
    repeat (4) step();
    glitch_valid = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      si16 = (cyc < 3) ? 1'b0 : 1'b1;
      step();
      if (vld16) glitch_valid++;
      if (cyc + 1 == 7) begin
        checks++; if (bsy16 !== 1'b1) begin errors++; $display("FAIL glitch_busy_hold: got %b expected 1 at t0+7", bsy16); end
      end
      if (cyc + 1 == 8) begin
        checks++; if (bsy16 !== 1'b0) begin errors++; $display("FAIL glitch_busy_drop: got %b expected 0 at t0+8", bsy16); end
      end
    end
    checks++; if (glitch_valid !== 0) begin errors++; $display("FAIL glitch_valid: got %0d expected 0", glitch_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_errors();
    test_overrun();
    test_reset_mid();
    test_break();
    test_oversample();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
